// File: rtl/timer_pkg.sv
// Shared definitions for the 16-bit timer: FSM state encoding, clock-select codes, default width.
package timer_pkg;

    localparam int TIMER_CNT_W = 16;

    // 2'b11 is unused and decodes to IDLE in the controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Converts the pclk-synchronous divided clock level into a one-pclk tick per rising edge.
module timer_tick_gen (
    input  logic pclk,
    input  logic rst_n,
    input  logic clk_in,
    output logic o_tick
);

    logic r_clk_in_d;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_clk_in_d <= 1'b0;
        else        r_clk_in_d <= clk_in;
    end

    assign o_tick = clk_in & ~r_clk_in_d;

endmodule

// File: rtl/timer_ctrl.sv
// Timer count control: load/idle/count sequencing, up/down counter, sticky wrap flags.
// Optional interrupt output enabled by defining TIMER_CTRL_IRQ_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = TIMER_CNT_W
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic [CNT_W-1:0] tdr,
    input  logic             load,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ovf_clr,
    input  logic             unf_clr,
`ifdef TIMER_CTRL_IRQ_EN
    input  logic             ovf_ie,
    input  logic             unf_ie,
    output logic             irq,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             r_unf;
    logic             w_tick;
    logic             w_step;
    logic             w_ovf_set;
    logic             w_unf_set;

    timer_tick_gen u_tick_gen (
        .pclk   (pclk),
        .rst_n  (rst_n),
        .clk_in (clk_in),
        .o_tick (w_tick)
    );

    // load wins from any state; a tick is only consumed while counting with en held.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_step      = 1'b0;
        if (load) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:  w_state_nxt = en ? ST_COUNT : ST_IDLE;
                ST_COUNT: begin
                    if (en) begin
                        w_state_nxt = ST_COUNT;
                        w_step      = w_tick;
                    end
                end
                default:  w_state_nxt = en ? ST_COUNT : ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load)        w_cnt_nxt = tdr;
        else if (w_step) w_cnt_nxt = up_dn ? (r_cnt - CNT_W'(1)) : (r_cnt + CNT_W'(1));
    end

    assign w_ovf_set = w_step & ~up_dn & (r_cnt == {CNT_W{1'b1}});
    assign w_unf_set = w_step &  up_dn & (r_cnt == {CNT_W{1'b0}});

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
            if (w_unf_set)    r_unf <= 1'b1;
            else if (unf_clr) r_unf <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign ovf  = r_ovf;
    assign unf  = r_unf;
    assign busy = (r_state == ST_COUNT);

`ifdef TIMER_CTRL_IRQ_EN
    assign irq = (r_ovf & ovf_ie) | (r_unf & unf_ie);
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; interrupt checks are built when TIMER_CTRL_IRQ_EN is defined.
module tb_timer_ctrl;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        clk_in;
    logic [15:0] tdr;
    logic        load, en, up_dn, ovf_clr, unf_clr;
    logic [15:0] cnt;
    logic        ovf, unf, busy;
`ifdef TIMER_CTRL_IRQ_EN
    logic        ovf_ie, unf_ie, irq;
`endif

    int          n_chk  = 0;
    int          n_pass = 0;
    logic        div_on = 1'b0;
    logic [1:0]  div_ph = 2'd0;
    logic [18:0] e;
    wire  [18:0] obs = {cnt, ovf, unf, busy};

    always #10 pclk = ~pclk;

    timer_ctrl #(.CNT_W(16)) dut (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .clk_in  (clk_in),
        .tdr     (tdr),
        .load    (load),
        .en      (en),
        .up_dn   (up_dn),
        .ovf_clr (ovf_clr),
        .unf_clr (unf_clr),
`ifdef TIMER_CTRL_IRQ_EN
        .ovf_ie  (ovf_ie),
        .unf_ie  (unf_ie),
        .irq     (irq),
`endif
        .cnt     (cnt),
        .ovf     (ovf),
        .unf     (unf),
        .busy    (busy)
    );

    // Inputs change on the falling edge; outputs are read there too, half a period after the active edge.
    task automatic cyc();
        @(negedge pclk);
        if (div_on) begin
            div_ph = div_ph + 2'd1;
            clk_in = div_ph[1];
        end
    endtask

    task automatic pulse_tick();
        clk_in = 1'b1;
        cyc();
        clk_in = 1'b0;
        cyc();
    endtask

    task automatic start(input logic [15:0] v, input logic dn);
        tdr = v; load = 1'b1; en = 1'b1; up_dn = dn;
        cyc();
        load = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        #5;
        e = {16'h0000, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL reset_init: got %h want %h", obs, e); else n_pass++;
        @(negedge pclk) rst_n = 1'b1;
        cyc();
        start(16'hFFFF, 1'b0);
        pulse_tick();
        e = {16'h0000, 3'b101}; n_chk++;
        if (obs !== e) $display("FAIL reset_setup_wrap: got %h want %h", obs, e); else n_pass++;
        tdr = 16'h1234; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        e = {16'h1234, 3'b101}; n_chk++;
        if (obs !== e) $display("FAIL reset_setup_run: got %h want %h", obs, e); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        e = {16'h0000, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL reset_async: got %h want %h", obs, e); else n_pass++;
        en = 1'b0;
        @(negedge pclk) rst_n = 1'b1;
        cyc();
        e = {16'h0000, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL reset_release: got %h want %h", obs, e); else n_pass++;
    endtask

    task automatic test_load_count();
        tdr = 16'h0010; load = 1'b1; en = 1'b1; up_dn = 1'b0;
        cyc();
        load = 1'b0;
        e = {16'h0010, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL lc_load_state: got %h want %h", obs, e); else n_pass++;
        cyc();
        e = {16'h0010, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL lc_busy: got %h want %h", obs, e); else n_pass++;
        div_ph = 2'd0; div_on = 1'b1;
        cyc(); cyc();
        e = {16'h0010, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL lc_pre_edge: got %h want %h", obs, e); else n_pass++;
        cyc();
        e = {16'h0011, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL lc_step1: got %h want %h", obs, e); else n_pass++;
        for (int k = 2; k <= 4; k++) begin
            repeat (4) cyc();
            e = {16'h0010 + 16'(k), 3'b001}; n_chk++;
            if (obs !== e) $display("FAIL lc_step%0d: got %h want %h", k, obs, e); else n_pass++;
        end
        div_on = 1'b0; clk_in = 1'b0; en = 1'b0;
        cyc(); cyc();
        e = {16'h0014, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL lc_stop: got %h want %h", obs, e); else n_pass++;
    endtask

    task automatic test_overflow();
        start(16'hFFFE, 1'b0);
        pulse_tick();
        e = {16'hFFFF, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL ovf_allones: got %h want %h", obs, e); else n_pass++;
        pulse_tick();
        e = {16'h0000, 3'b101}; n_chk++;
        if (obs !== e) $display("FAIL ovf_wrap: got %h want %h", obs, e); else n_pass++;
        start(16'hFFFF, 1'b0);
        e = {16'hFFFF, 3'b101}; n_chk++;
        if (obs !== e) $display("FAIL ovf_load_keeps_flag: got %h want %h", obs, e); else n_pass++;
        clk_in = 1'b1; ovf_clr = 1'b1;
        cyc();
        clk_in = 1'b0; ovf_clr = 1'b0;
        e = {16'h0000, 3'b101}; n_chk++;
        if (obs !== e) $display("FAIL ovf_set_beats_clr: got %h want %h", obs, e); else n_pass++;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        e = {16'h0000, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL ovf_clr: got %h want %h", obs, e); else n_pass++;
        en = 1'b0;
        cyc();
    endtask

    task automatic test_underflow();
        start(16'h0001, 1'b1);
        pulse_tick();
        e = {16'h0000, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL unf_zero: got %h want %h", obs, e); else n_pass++;
        pulse_tick();
        e = {16'hFFFF, 3'b011}; n_chk++;
        if (obs !== e) $display("FAIL unf_wrap: got %h want %h", obs, e); else n_pass++;
        unf_clr = 1'b1;
        cyc();
        unf_clr = 1'b0;
        e = {16'hFFFF, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL unf_clr: got %h want %h", obs, e); else n_pass++;
        en = 1'b0; up_dn = 1'b0;
        cyc();
    endtask

    task automatic test_priority_stop();
        start(16'h0050, 1'b0);
        pulse_tick();
        e = {16'h0051, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL pri_step: got %h want %h", obs, e); else n_pass++;
        tdr = 16'h0100; load = 1'b1; clk_in = 1'b1;
        cyc();
        load = 1'b0; clk_in = 1'b0;
        e = {16'h0100, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL pri_load_vs_tick: got %h want %h", obs, e); else n_pass++;
        cyc();
        e = {16'h0100, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL pri_after_load: got %h want %h", obs, e); else n_pass++;
        tdr = 16'h0200; load = 1'b1;
        cyc();
        load = 1'b0; clk_in = 1'b1;
        cyc();
        clk_in = 1'b0;
        e = {16'h0200, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL pri_tick_in_load: got %h want %h", obs, e); else n_pass++;
        cyc();
        pulse_tick();
        up_dn = 1'b1;
        pulse_tick();
        e = {16'h0200, 3'b001}; n_chk++;
        if (obs !== e) $display("FAIL pri_dir_change: got %h want %h", obs, e); else n_pass++;
        en = 1'b0; clk_in = 1'b1;
        cyc();
        clk_in = 1'b0;
        e = {16'h0200, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL stop_edge: got %h want %h", obs, e); else n_pass++;
        cyc();
        repeat (3) pulse_tick();
        e = {16'h0200, 3'b000}; n_chk++;
        if (obs !== e) $display("FAIL stop_frozen: got %h want %h", obs, e); else n_pass++;
        up_dn = 1'b0;
    endtask

`ifdef TIMER_CTRL_IRQ_EN
    task automatic test_irq();
        ovf_ie = 1'b1; unf_ie = 1'b0;
        #1;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL irq_idle: got %b want 0", irq); else n_pass++;
        start(16'hFFFF, 1'b0);
        pulse_tick();
        start(16'h0000, 1'b1);
        pulse_tick();
        e = {16'hFFFF, 3'b111}; n_chk++;
        if (obs !== e) $display("FAIL irq_flags: got %h want %h", obs, e); else n_pass++;
        n_chk++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b want 1", irq); else n_pass++;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        n_chk++;
        if (irq !== 1'b0) $display("FAIL irq_ovf_clr: got %b want 0", irq); else n_pass++;
        unf_ie = 1'b1;
        #1;
        n_chk++;
        if (irq !== 1'b1) $display("FAIL irq_unf_ie: got %b want 1", irq); else n_pass++;
        unf_ie = 1'b0; unf_clr = 1'b1; en = 1'b0; up_dn = 1'b0;
        cyc();
        unf_clr = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; clk_in = 1'b0; tdr = '0; load = 1'b0; en = 1'b0;
        up_dn = 1'b0; ovf_clr = 1'b0; unf_clr = 1'b0;
`ifdef TIMER_CTRL_IRQ_EN
        ovf_ie = 1'b0; unf_ie = 1'b0;
`endif
        test_reset();
        test_load_count();
        test_overflow();
        test_underflow();
        test_priority_stop();
`ifdef TIMER_CTRL_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
